// File: rtl/ibus_icache.sv
// ibus_icache: direct-mapped, blocking instruction cache between the core's
// instruction bus and the CBus arbiter's instruction port.
//
// Hits answer combinationally in the request cycle. A cacheable miss refills
// one whole line with an INCR burst. A fetch from the device region
// (addr[31]==0) is passed through as a single-beat read and is never cached.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   ireq_valid_i        fetch request valid
//   ireq_addr_i         fetch address (physical, 4-byte aligned)
//   iresp_addr_ok_o     request accepted
//   iresp_data_ok_o     instruction word valid
//   iresp_data_o        32-bit instruction
//   icreq_*_o           CBus request: valid, is_write, size, addr, strobe,
//                       data, len, burst
//   icresp_ready_i      CBus beat valid
//   icresp_last_i       final beat of the transaction
//   icresp_data_i       64-bit beat data
//   flush               fence.i invalidate-all pulse
module ibus_icache #(
    parameter int NSETS = 16,
    parameter int BEATS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid_i,
    input  logic [63:0] ireq_addr_i,
    output logic        iresp_addr_ok_o,
    output logic        iresp_data_ok_o,
    output logic [31:0] iresp_data_o,
    output logic        icreq_valid_o,
    output logic        icreq_is_write_o,
    output logic [2:0]  icreq_size_o,
    output logic [63:0] icreq_addr_o,
    output logic [7:0]  icreq_strobe_o,
    output logic [63:0] icreq_data_o,
    output logic [3:0]  icreq_len_o,
    output logic [1:0]  icreq_burst_o,
    input  logic        icresp_ready_i,
    input  logic        icresp_last_i,
    input  logic [63:0] icresp_data_i,
    input  logic        flush
);

    localparam int OFF_W  = $clog2(8 * BEATS);
    localparam int IDX_W  = $clog2(NSETS);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int TAG_W  = 64 - OFF_W - IDX_W;

    localparam logic [2:0] MSIZE4      = 3'b010;
    localparam logic [2:0] MSIZE8      = 3'b011;
    localparam logic [3:0] MLEN1       = 4'b0000;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_UNCACHED
    } state_t;

    // Storage
    logic [63:0]      data_q [NSETS*BEATS];
    logic [TAG_W-1:0] tag_q  [NSETS];
    logic [NSETS-1:0] valid_q;

    // Control
    state_t            state_q;
    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;
    logic              flush_pending_q;
    logic              fill_fwd_q;

    // Registered bus request
    logic        icreq_valid_q;
    logic [2:0]  size_q;
    logic [63:0] addr_q;
    logic [3:0]  len_q;
    logic [1:0]  burst_q;

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  fill_tag;
    logic [BEAT_W-1:0] req_beat;
    logic [63:0]       hit_beat;
    logic              tag_hit;
    logic              fwd_hit;
    logic              req_hit;

    assign req_idx  = ireq_addr_i[OFF_W +: IDX_W];
    assign req_tag  = ireq_addr_i[63 -: TAG_W];
    assign req_beat = ireq_addr_i[3 +: BEAT_W];
    // During and right after a refill addr_q holds the line address, so the
    // fill index and tag come straight from it.
    assign fill_idx = addr_q[OFF_W +: IDX_W];
    assign fill_tag = addr_q[63 -: TAG_W];
    assign beat_d   = beat_q + 1'b1;
    assign hit_beat = data_q[{req_idx, req_beat}];

    assign tag_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // For one cycle after a refill the just-filled line answers the held
    // fetch even if a flush during the burst kept it from being marked
    // valid; the fetch is delivered once but the line stays uncached.
    assign fwd_hit = fill_fwd_q && (ireq_addr_i[63:OFF_W] == addr_q[63:OFF_W]);
    assign req_hit = (state_q == S_IDLE) && ireq_valid_i && ireq_addr_i[31] &&
                     (tag_hit || fwd_hit);

    always_comb begin
        iresp_addr_ok_o = 1'b0;
        iresp_data_ok_o = 1'b0;
        iresp_data_o    = 32'h0;
        if (req_hit) begin
            iresp_addr_ok_o = 1'b1;
            iresp_data_ok_o = 1'b1;
            iresp_data_o    = ireq_addr_i[2] ? hit_beat[63:32] : hit_beat[31:0];
        end else if ((state_q == S_UNCACHED) && icresp_ready_i) begin
            iresp_addr_ok_o = 1'b1;
            iresp_data_ok_o = 1'b1;
            iresp_data_o    = addr_q[2] ? icresp_data_i[63:32] : icresp_data_i[31:0];
        end
    end

    assign icreq_valid_o    = icreq_valid_q;
    assign icreq_is_write_o = 1'b0;
    assign icreq_size_o     = size_q;
    assign icreq_addr_o     = addr_q;
    assign icreq_strobe_o   = 8'h0;
    assign icreq_data_o     = 64'h0;
    assign icreq_len_o      = len_q;
    assign icreq_burst_o    = burst_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            icreq_valid_q   <= 1'b0;
            size_q          <= 3'b000;
            addr_q          <= 64'h0;
            len_q           <= 4'h0;
            burst_q         <= 2'b00;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            fill_fwd_q      <= 1'b0;
            valid_q         <= '0;
        end else begin
            fill_fwd_q <= 1'b0;
            if (flush) begin
                valid_q <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (ireq_valid_i && !req_hit) begin
                        icreq_valid_q <= 1'b1;
                        if (ireq_addr_i[31]) begin
                            state_q <= S_REFILL;
                            size_q  <= MSIZE8;
                            addr_q  <= {ireq_addr_i[63:OFF_W], {OFF_W{1'b0}}};
                            len_q   <= 4'(BEATS - 1);
                            burst_q <= BURST_INCR;
                            beat_q  <= '0;
                        end else begin
                            state_q <= S_UNCACHED;
                            size_q  <= MSIZE4;
                            addr_q  <= ireq_addr_i;
                            len_q   <= MLEN1;
                            burst_q <= BURST_FIXED;
                        end
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (icresp_ready_i) begin
                        beat_q <= beat_d;
                        if (icresp_last_i) begin
                            state_q         <= S_IDLE;
                            icreq_valid_q   <= 1'b0;
                            beat_q          <= '0;
                            flush_pending_q <= 1'b0;
                            fill_fwd_q      <= 1'b1;
                            // A flush seen at any point of the burst keeps
                            // the line invalid.
                            if (!flush && !flush_pending_q) begin
                                valid_q[fill_idx] <= 1'b1;
                            end
                        end
                    end
                end
                S_UNCACHED: begin
                    if (icresp_ready_i) begin
                        state_q       <= S_IDLE;
                        icreq_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Line data and tags carry no reset; valid_q alone qualifies them. The
    // tag is written only with the final beat, so a burst cut short by reset
    // never leaves a matching tag behind.
    always_ff @(posedge clk) begin
        if ((state_q == S_REFILL) && icresp_ready_i) begin
            data_q[{fill_idx, beat_q}] <= icresp_data_i;
            if (icresp_last_i) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_ibus_icache.sv
module tb_ibus_icache;

    logic        clk;
    logic        reset;
    logic        ireq_valid_i;
    logic [63:0] ireq_addr_i;
    logic        iresp_addr_ok_o;
    logic        iresp_data_ok_o;
    logic [31:0] iresp_data_o;
    logic        icreq_valid_o;
    logic        icreq_is_write_o;
    logic [2:0]  icreq_size_o;
    logic [63:0] icreq_addr_o;
    logic [7:0]  icreq_strobe_o;
    logic [63:0] icreq_data_o;
    logic [3:0]  icreq_len_o;
    logic [1:0]  icreq_burst_o;
    logic        icresp_ready_i;
    logic        icresp_last_i;
    logic [63:0] icresp_data_i;
    logic        flush;

    ibus_icache #(.NSETS(16), .BEATS(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .ireq_valid_i     (ireq_valid_i),
        .ireq_addr_i      (ireq_addr_i),
        .iresp_addr_ok_o  (iresp_addr_ok_o),
        .iresp_data_ok_o  (iresp_data_ok_o),
        .iresp_data_o     (iresp_data_o),
        .icreq_valid_o    (icreq_valid_o),
        .icreq_is_write_o (icreq_is_write_o),
        .icreq_size_o     (icreq_size_o),
        .icreq_addr_o     (icreq_addr_o),
        .icreq_strobe_o   (icreq_strobe_o),
        .icreq_data_o     (icreq_data_o),
        .icreq_len_o      (icreq_len_o),
        .icreq_burst_o    (icreq_burst_o),
        .icresp_ready_i   (icresp_ready_i),
        .icresp_last_i    (icresp_last_i),
        .icresp_data_i    (icresp_data_i),
        .flush            (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing memory: one fixed word pair at 0x8000_0000, elsewhere a
    // deterministic function of the 8-byte-aligned address.
    function automatic logic [63:0] mem64(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0000_0013_0000_0093;
        return {a[31:0] ^ 32'h1357_9BDF, a[31:0] + 32'h0246_8ACE};
    endfunction

    function automatic logic [31:0] word_of(input logic [63:0] a);
        logic [63:0] m;
        m = mem64({a[63:3], 3'b000});
        return a[2] ? m[63:32] : m[31:0];
    endfunction

    // CBus slave with random wait states
    logic        sl_busy = 1'b0;
    int          sl_beat = 0;
    int          sl_len = 0;
    int          sl_wait = 0;
    logic [63:0] sl_addr = 64'h0;
    logic [1:0]  sl_burst = 2'b00;
    int          bursts = 0;
    int          beats_cur = 0;
    int          beats_last = 0;
    int          last_cyc = 0;
    logic [2:0]  rq_size = 3'b000;
    logic [3:0]  rq_len = 4'h0;
    logic [1:0]  rq_burst = 2'b00;
    logic [63:0] rq_addr = 64'h0;
    logic        rq_misc = 1'b0;

    initial begin
        icresp_ready_i = 1'b0;
        icresp_last_i  = 1'b0;
        icresp_data_i  = 64'h0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                sl_busy        = 1'b0;
                icresp_ready_i = 1'b0;
                icresp_last_i  = 1'b0;
                continue;
            end
            if (icresp_ready_i) begin
                beats_cur++;
                if (icresp_last_i) begin
                    sl_busy    = 1'b0;
                    beats_last = beats_cur;
                end else begin
                    sl_beat++;
                end
            end
            icresp_ready_i = 1'b0;
            icresp_last_i  = 1'b0;
            if (!sl_busy && icreq_valid_o) begin
                sl_busy   = 1'b1;
                sl_addr   = icreq_addr_o;
                sl_len    = int'(icreq_len_o);
                sl_burst  = icreq_burst_o;
                rq_addr   = icreq_addr_o;
                rq_size   = icreq_size_o;
                rq_len    = icreq_len_o;
                rq_burst  = icreq_burst_o;
                rq_misc   = icreq_is_write_o | (|icreq_strobe_o) | (|icreq_data_o);
                bursts++;
                sl_beat   = 0;
                beats_cur = 0;
                sl_wait   = $urandom_range(0, 2);
            end else if (sl_busy) begin
                chk("req_hold_valid", icreq_valid_o, 1'b1);
                chk("req_hold_addr", icreq_addr_o, sl_addr);
            end
            if (sl_busy) begin
                if (sl_wait > 0) begin
                    sl_wait--;
                end else begin
                    icresp_ready_i = 1'b1;
                    icresp_data_i  = (sl_burst == 2'b01) ?
                                     mem64(sl_addr + 64'(8 * sl_beat)) :
                                     mem64({sl_addr[63:3], 3'b000});
                    icresp_last_i  = (sl_beat == sl_len);
                    last_cyc       = cyc;
                    sl_wait        = $urandom_range(0, 1);
                end
            end
        end
    end

    // Reference model: which line address each set holds, if any.
    logic        ref_vld  [16];
    logic [63:0] ref_line [16];
    logic [31:0] last_data;

    task automatic ref_clear();
        for (int i = 0; i < 16; i++) ref_vld[i] = 1'b0;
    endtask

    // Issue one fetch and hold it until data_ok. flush_beat >= 0 pulses
    // flush while that refill beat is on the bus.
    task automatic fetch(input logic [63:0] a, input int flush_beat);
        logic        cach;
        logic        miss;
        logic        got;
        logic        flushed;
        logic [63:0] line;
        int          idx;
        int          b0;
        int          waitc;
        cach    = a[31];
        line    = {a[63:5], 5'b00000};
        idx     = int'(a[8:5]);
        miss    = !cach || !(ref_vld[idx] && ref_line[idx] == line);
        b0      = bursts;
        waitc   = 0;
        got     = 1'b0;
        flushed = 1'b0;
        ireq_valid_i = 1'b1;
        ireq_addr_i  = a;
        while (!got && waitc < 200) begin
            @(negedge clk);
            if (iresp_data_ok_o) begin
                got = 1'b1;
            end else begin
                if (flush_beat >= 0 && !flushed && icresp_ready_i && sl_beat == flush_beat) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                end
                waitc++;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
        end
        chk("data_ok_seen", got, 1'b1);
        if (got) begin
            last_data = iresp_data_o;
            chk("fetch_data", iresp_data_o, word_of(a));
            chk("addr_ok", iresp_addr_ok_o, 1'b1);
            chk("burst_count", 64'(bursts - b0), 64'(miss));
            if (miss) begin
                chk("miss_latency", 64'(cyc - last_cyc), cach ? 64'd1 : 64'd0);
                chk("req_misc_zero", rq_misc, 1'b0);
                if (cach) begin
                    chk("refill_addr", rq_addr, line);
                    chk("refill_len", rq_len, 4'd3);
                    chk("refill_size", rq_size, 3'b011);
                    chk("refill_burst", rq_burst, 2'b01);
                    chk("refill_beats", 64'(beats_last), 64'd4);
                end else begin
                    chk("unc_addr", rq_addr, a);
                    chk("unc_len", rq_len, 4'd0);
                    chk("unc_size", rq_size, 3'b010);
                    chk("unc_burst", rq_burst, 2'b00);
                end
            end else begin
                chk("hit_wait", 64'(waitc), 64'd0);
                chk("hit_no_req", icreq_valid_o, 1'b0);
            end
        end
        if (cach && miss) begin
            if (flushed) begin
                ref_clear();
            end else begin
                ref_vld[idx]  = 1'b1;
                ref_line[idx] = line;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        ireq_valid_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic flush_idle();
        ireq_valid_i = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        ref_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r;
        logic [63:0] a;
        reset        = 1'b1;
        ireq_valid_i = 1'b0;
        ireq_addr_i  = 64'h0;
        flush        = 1'b0;
        last_data    = 32'h0;
        ref_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_icreq_valid", icreq_valid_o, 1'b0);
        chk("rst_addr_ok", iresp_addr_ok_o, 1'b0);
        chk("rst_data_ok", iresp_data_ok_o, 1'b0);
        chk("rst_data", iresp_data_o, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycle();

        // Cold miss, then the other word of the same beat hits.
        fetch(64'h8000_0000, -1);
        chk("cold_word0", last_data, 32'h0000_0093);
        fetch(64'h8000_0004, -1);
        chk("cold_word1", last_data, 32'h0000_0013);
        idle_cycle();

        // Sequential stream through a fresh line.
        for (int i = 0; i < 8; i++) fetch(64'h8000_0020 + 64'(4 * i), -1);
        idle_cycle();

        // Conflict on set 0.
        fetch(64'h8000_0200, -1);
        fetch(64'h8000_0000, -1);
        fetch(64'h8000_0200, -1);
        idle_cycle();

        // Uncached, repeated.
        fetch(64'h0000_1004, -1);
        chk("unc_upper", last_data, word_of(64'h0000_1004));
        idle_cycle();
        fetch(64'h0000_1004, -1);
        idle_cycle();

        // Flush during refill, then the line must miss again.
        fetch(64'h8000_0040, 2);
        idle_cycle();
        fetch(64'h8000_0040, -1);
        idle_cycle();

        // Flush in idle after warm-up.
        fetch(64'h8000_0060, -1);
        fetch(64'h8000_0064, -1);
        flush_idle();
        fetch(64'h8000_0060, -1);
        fetch(64'h8000_0040, -1);
        idle_cycle();

        // Reset mid-burst.
        ireq_valid_i = 1'b1;
        ireq_addr_i  = 64'h8000_0100;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (sl_busy && sl_beat == 2) break;
            n++;
        end
        chk("midburst_reached", 64'(n < 200), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_icreq_valid", icreq_valid_o, 1'b0);
        chk("midrst_data_ok", iresp_data_ok_o, 1'b0);
        ireq_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ref_clear();
        idle_cycle();
        fetch(64'h8000_0100, -1);
        idle_cycle();

        // Randomized traffic.
        for (int k = 0; k < 120; k++) begin
            r = $urandom_range(0, 11);
            if (r == 0) begin
                flush_idle();
            end else if (r == 1) begin
                fetch(64'h0000_1000 + 64'(4 * $urandom_range(0, 15)), -1);
            end else begin
                a = 64'h8000_0000 + 64'($urandom_range(0, 3) << 9) +
                    64'($urandom_range(0, 3) << 5) + 64'(4 * $urandom_range(0, 7));
                fetch(a, (r == 2) ? $urandom_range(0, 3) : -1);
            end
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
